// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: walks every memblock word, writing it back to memory (flush) or refilling it.
// The refill path is built only when DCACHE_FLUSH_FILL_EN is defined.
module dcache_flush_ctrl #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 5,
  parameter int MEMSIZE  = 2**ADDRBITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_start,
  input  logic                fill_start,
  input  logic [31:0]         mem_base,
  output logic                busy,
  output logic                done,
  output logic                flush_mode,
  output logic [ADDRBITS-1:0] flush_addr,
  output logic [DATABITS-1:0] flush_in,
  output logic                flush_we,
  input  logic [DATABITS-1:0] flush_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DATABITS-1:0] mem_wdata,
  input  logic [DATABITS-1:0] mem_rdata,
  input  logic                mem_ack
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WB, FREQ, FWR, DONE} state_t;

  typedef struct packed {
    logic                req;
    logic                we;
    logic [31:0]         addr;
    logic [DATABITS-1:0] wdata;
  } mreq_t;

  localparam logic [ADDRBITS-1:0] LAST = ADDRBITS'(MEMSIZE - 1);

  state_t              state;
  logic [ADDRBITS-1:0] idx;
  logic [ADDRBITS-1:0] idx_nxt;
  logic [31:0]         base;
  logic [31:0]         base_in;
  mreq_t               mreq;
  logic                unused;

  assign idx_nxt   = idx + ADDRBITS'(1);
  assign base_in   = {mem_base[31:2], 2'b00};
  assign mem_req   = mreq.req;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;

`ifdef DCACHE_FLUSH_FILL_EN
  logic fill_pend;
  assign unused = ^mem_base[1:0];
`else
  assign unused = ^{mem_base[1:0], fill_start, mem_rdata};
`endif

  // Byte address of word i; 32-bit wraparound is intentional.
  function automatic logic [31:0] word_addr(input logic [31:0] b, input logic [ADDRBITS-1:0] i);
    return b + (32'(i) << 2);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      base       <= '0;
      mreq       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      flush_mode <= 1'b0;
      flush_addr <= '0;
      flush_in   <= '0;
      flush_we   <= 1'b0;
`ifdef DCACHE_FLUSH_FILL_EN
      fill_pend  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      flush_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_start) begin
            base       <= base_in;
            idx        <= '0;
            flush_addr <= '0;
            busy       <= 1'b1;
            flush_mode <= 1'b1;
            state      <= RD;
`ifdef DCACHE_FLUSH_FILL_EN
            fill_pend  <= fill_start;
`endif
          end
`ifdef DCACHE_FLUSH_FILL_EN
          else if (fill_start) begin
            base       <= base_in;
            idx        <= '0;
            flush_addr <= '0;
            busy       <= 1'b1;
            flush_mode <= 1'b1;
            mreq.req   <= 1'b1;
            mreq.we    <= 1'b0;
            mreq.addr  <= base_in;
            state      <= FREQ;
          end
`endif
        end
        RD: state <= CAP;
        // memblock data for idx arrives this cycle; it becomes the write-back payload
        CAP: begin
          mreq  <= '{req: 1'b1, we: 1'b1, addr: word_addr(base, idx), wdata: flush_rdata};
          state <= WB;
        end
        WB: begin
          if (mem_ack) begin
            if (idx != LAST) begin
              mreq.req   <= 1'b0;
              mreq.we    <= 1'b0;
              mreq.addr  <= '0;
              idx        <= idx_nxt;
              flush_addr <= idx_nxt;
              state      <= RD;
            end
`ifdef DCACHE_FLUSH_FILL_EN
            // pending refill chains straight on, request stays asserted
            else if (fill_pend) begin
              fill_pend  <= 1'b0;
              idx        <= '0;
              flush_addr <= '0;
              mreq.we    <= 1'b0;
              mreq.addr  <= base;
              state      <= FREQ;
            end
`endif
            else begin
              mreq.req   <= 1'b0;
              mreq.we    <= 1'b0;
              mreq.addr  <= '0;
              busy       <= 1'b0;
              flush_mode <= 1'b0;
              flush_addr <= '0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
`ifdef DCACHE_FLUSH_FILL_EN
        FREQ: begin
          if (mem_ack) begin
            flush_in  <= mem_rdata;
            flush_we  <= 1'b1;
            mreq.req  <= 1'b0;
            mreq.addr <= '0;
            state     <= FWR;
          end
        end
        FWR: begin
          if (idx != LAST) begin
            idx        <= idx_nxt;
            flush_addr <= idx_nxt;
            mreq.req   <= 1'b1;
            mreq.addr  <= word_addr(base, idx_nxt);
            state      <= FREQ;
          end else begin
            busy       <= 1'b0;
            flush_mode <= 1'b0;
            flush_addr <= '0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Scoreboard bench for dcache_flush_ctrl: randomized walks checked against a word-level model.
// Refill scenarios are exercised when DCACHE_FLUSH_FILL_EN is defined.
module tb_dcache_flush_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;
`ifdef DCACHE_FLUSH_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic          clk = 1'b0, reset_n = 1'b0, flush_start = 1'b0, fill_start = 1'b0;
  logic [31:0]   mem_base = '0;
  logic          busy, done, flush_mode, flush_we, mem_req, mem_we;
  logic [AW-1:0] flush_addr;
  logic [DW-1:0] flush_in, flush_rdata, mem_wdata;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  dcache_flush_ctrl #(.DATABITS(DW), .ADDRBITS(AW)) dut (
    .clk(clk), .reset_n(reset_n), .flush_start(flush_start), .fill_start(fill_start),
    .mem_base(mem_base), .busy(busy), .done(done), .flush_mode(flush_mode),
    .flush_addr(flush_addr), .flush_in(flush_in), .flush_we(flush_we),
    .flush_rdata(flush_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // memblock: registered read, one-cycle latency
  logic [DW-1:0] mb       [N];
  logic [DW-1:0] load_img [N];
  logic [DW-1:0] ref_mb   [N];
  logic          load_all = 1'b0;
  always @(posedge clk) begin
    if (load_all) for (int i = 0; i < N; i++) mb[i] <= load_img[i];
    else if (flush_we) mb[flush_addr] <= flush_in;
    flush_rdata <= mb[flush_addr];
  end

  // memory responder: word at address a holds rd_pat + (a - rd_base)/4
  bit            noise_en = 0, stall_en = 0;
  logic [AW-1:0] stall_idx = '0;
  int            dly_lo = 0, dly_hi = 0, cur_dly = 0, wait_cnt = 0;
  logic [31:0]   rd_pat = '0, rd_base = '0;
  always @(posedge clk) begin
    #1;
    if (mem_req && !(stall_en && flush_addr == stall_idx)) begin
      if (wait_cnt >= cur_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_pat + ((mem_addr - rd_base) >> 2);
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack   = noise_en && !mem_req && ($urandom_range(3) == 0);
      mem_rdata = $urandom;
      wait_cnt  = 0;
      cur_dly   = $urandom_range(dly_hi, dly_lo);
    end
  end

  typedef struct { logic we; logic [31:0] addr; logic [DW-1:0] data; } txn_t;
  typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; } fw_t;
  txn_t exp_q[$];
  fw_t  fw_q[$];
  int   exp_done = 0;
  int   vecs = 0, errs = 0;
  txn_t mon_e;
  fw_t  mon_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string msg);
    vecs++;
    errs++;
    $display("FAIL %s", msg);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a transaction
  always @(negedge clk) if (reset_n) begin
    if (mem_req && mem_ack) begin
      if (exp_q.size() == 0) bad($sformatf("mem_txn unexpected addr %0h", mem_addr));
      else begin
        mon_e = exp_q.pop_front();
        chk("mem_we", {63'b0, mem_we}, {63'b0, mon_e.we});
        chk("mem_addr", {32'b0, mem_addr}, {32'b0, mon_e.addr});
        if (mon_e.we) chk("mem_wdata", {32'b0, mem_wdata}, {32'b0, mon_e.data});
      end
    end
    if (flush_we) begin
      if (fw_q.size() == 0) bad($sformatf("flush_we unexpected idx %0d", flush_addr));
      else begin
        mon_f = fw_q.pop_front();
        chk("fill_idx", {59'b0, flush_addr}, {59'b0, mon_f.idx});
        chk("fill_data", {32'b0, flush_in}, {32'b0, mon_f.data});
      end
    end
    if (done) begin
      if (exp_done == 0) bad("done unexpected");
      else begin
        exp_done--;
        chk("busy_with_done", {63'b0, busy}, 64'd0);
      end
    end
    chk("mode_eq_busy", {63'b0, flush_mode}, {63'b0, busy});
    if (!busy) chk("idle_quiet", {57'b0, flush_addr, mem_req, flush_we}, 64'd0);
  end

  // reference model: what one operation must produce, word by word
  task automatic expect_op(input bit f, input bit fl, input logic [31:0] base);
    logic [31:0] b;
    b = {base[31:2], 2'b00};
    if (f) for (int i = 0; i < N; i++) exp_q.push_back('{1'b1, b + 32'(4 * i), ref_mb[i]});
    if (fl && FILL) for (int i = 0; i < N; i++) begin
      exp_q.push_back('{1'b0, b + 32'(4 * i), '0});
      fw_q.push_back('{AW'(i), rd_pat + 32'(i)});
      ref_mb[i] = rd_pat + 32'(i);
    end
    if (f || (fl && FILL)) exp_done++;
  endtask

  task automatic load_mem(input bit seq);
    for (int i = 0; i < N; i++) begin
      load_img[i] = seq ? 32'h1000 + 32'(i) : $urandom;
      ref_mb[i]   = load_img[i];
    end
    @(negedge clk); load_all = 1'b1;
    @(negedge clk); load_all = 1'b0;
  endtask

  task automatic check_mb();
    int nbad = 0;
    for (int i = 0; i < N; i++) if (mb[i] !== ref_mb[i]) nbad++;
    chk("memblock_words_wrong", 64'(nbad), 64'd0);
  endtask

  task automatic run_op(input bit f, input bit fl, input logic [31:0] base, input bit inj,
                        output int cyc);
    bit fired = 0;
    bit active;
    int gaps = 0;
    active  = f || (fl && FILL);
    rd_base = {base[31:2], 2'b00};
    expect_op(f, fl, base);
    @(negedge clk); flush_start = f; fill_start = fl; mem_base = base;
    @(posedge clk); cyc = 1;
    forever begin
      @(negedge clk); flush_start = 0; fill_start = 0;
      if (done || !active) break;
      if (!busy) gaps++;
      if (inj && !fired && flush_addr == 5) begin
        fired = 1; flush_start = 1; fill_start = FILL; mem_base = 32'h9000;
      end
      if (cyc > 3000) begin bad("done timeout"); break; end
      @(posedge clk); cyc++;
    end
    if (active) chk("busy_gap_cycles", 64'(gaps), 64'd0);
    if (inj) begin flush_start = 1; fill_start = FILL; end
    repeat (6) begin
      @(negedge clk); flush_start = 0; fill_start = !active && fl;
      chk("stays_idle", {61'b0, busy, mem_req, flush_we}, 64'd0);
    end
    fill_start = 0;
    chk("queues_drained", 64'(exp_q.size() + fw_q.size() + exp_done), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {54'b0, busy, done, flush_mode, flush_addr, flush_we, mem_req, mem_we}, 64'd0);
    chk({tag, "_data"}, {flush_in, mem_wdata}, 64'd0);
    chk({tag, "_addr"}, {32'b0, mem_addr}, 64'd0);
  endtask

  task automatic reset_mid();
    int n = 0;
    int cyc;
    stall_en = 1; stall_idx = 5'd7; dly_lo = 0; dly_hi = 0;
    load_mem(0);
    rd_base = 32'h4000_0100;
    expect_op(1, 0, 32'h4000_0102);
    @(negedge clk); flush_start = 1; mem_base = 32'h4000_0102;
    @(negedge clk); flush_start = 0;
    while (!(mem_req && mem_we && flush_addr == 5'd7) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) bad("never reached WB at idx 7");
    reset_n = 0;
    @(negedge clk);
    chk_zero("midrun_reset");
    exp_q.delete(); fw_q.delete(); exp_done = 0; stall_en = 0;
    reset_n = 1;
    repeat (5) @(negedge clk);
    run_op(1, 0, 32'h4000_0102, 0, cyc);
  endtask

  initial begin
    int cyc;
    bit f, fl;
    logic [31:0] base;
    reset_n = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1;

    // sequential pattern, unaligned base, immediate ack
    load_mem(1);
    run_op(1, 0, 32'h2003, 0, cyc);
    chk("flush_cycles", 64'(cyc), 64'd97);
    check_mb();

    // starts mid-run / in DONE and a base change are ignored
    load_mem(0);
    run_op(1, 0, 32'h0000_5008, 1, cyc);

    reset_mid();

`ifdef DCACHE_FLUSH_FILL_EN
    rd_pat = 32'hA5A5_0000; dly_lo = 3; dly_hi = 3;
    load_mem(0);
    run_op(0, 1, 32'h0000_3000, 0, cyc);
    chk("fill_cycles", 64'(cyc), 64'd161);
    check_mb();
    rd_pat = $urandom; dly_lo = 0; dly_hi = 0;
    load_mem(0);
    run_op(1, 1, 32'h0000_7004, 0, cyc);
    chk("flush_fill_cycles", 64'(cyc), 64'd161);
    check_mb();
`else
    load_mem(0);
    run_op(0, 1, 32'h0000_3000, 0, cyc);
    check_mb();
    run_op(1, 1, 32'h0000_7004, 0, cyc);
    chk("flush_only_cycles", 64'(cyc), 64'd97);
`endif

    noise_en = 1; dly_lo = 0; dly_hi = 3;
    for (int k = 0; k < 6; k++) begin
      f  = 1'($urandom_range(1));
      fl = 1'($urandom_range(1));
      if (!f && !fl) f = 1;
      base   = (k == 0) ? 32'hFFFF_FFC5 : $urandom;
      rd_pat = $urandom;
      load_mem(0);
      run_op(f, fl, base, 0, cyc);
      check_mb();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dcache_flush_ctrl.md
DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

Interface
REQ-001 Parameter DATABITS, 32, word width, SHALL match the memblock data width.
REQ-002 Parameter ADDRBITS, 5, memblock index width.
REQ-003 Parameter MEMSIZE, 2**ADDRBITS, words walked per operation.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge only.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 flush_start  in  1  request write-back of all MEMSIZE words to memory.
REQ-007 fill_start  in  1  request refill of all MEMSIZE words from memory.
REQ-008 mem_base  in  32  byte base address; bits [1:0] SHALL be ignored.
REQ-009 busy  out  1  high while an operation runs.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 flush_mode, flush_addr[ADDRBITS], flush_in[DATABITS], flush_we  out  memblock flush port.
REQ-012 flush_rdata  in  DATABITS  memblock data_out; valid one cycle after flush_addr is presented.
REQ-013 mem_req, mem_we, mem_addr[32], mem_wdata[DATABITS]  out  memory request; mem_rdata[DATABITS], mem_ack  in.

Function
REQ-014 States SHALL be IDLE, RD, CAP, WB, FREQ, FWR, DONE.
REQ-015 IDLE: on flush_start, latch {mem_base[31:2],2'b00}, idx=0, enter RD; else on fill_start (DCACHE_FLUSH_FILL_EN only), latch base, idx=0, enter FREQ.
REQ-016 flush_start and fill_start high together SHALL latch both; write-back runs first, then fill starts at idx=0 without visiting IDLE.
REQ-017 Starts outside IDLE SHALL be ignored; mem_base changes after latching SHALL have no effect.
REQ-018 flush_mode and busy SHALL be high in RD, CAP, WB, FREQ, FWR; low in IDLE and DONE.
REQ-019 flush_addr SHALL equal idx in every busy state; 0 otherwise.
REQ-020 RD: one cycle; CAP: one cycle, registers flush_rdata into mem_wdata at cycle end.
REQ-021 WB: mem_req=1, mem_we=1, mem_addr=base+4*idx; held stable until mem_ack sampled high.
REQ-022 FREQ: mem_req=1, mem_we=0, mem_addr=base+4*idx; on mem_ack, register mem_rdata into flush_in, enter FWR.
REQ-023 FWR: flush_we=1 for exactly one cycle with flush_in, flush_addr=idx; flush_we SHALL be 0 in all other states.
REQ-024 After WB ack or FWR: if idx==MEMSIZE-1, next is fill phase (if pending) or DONE; else idx+1 and RD or FREQ.
REQ-025 idx SHALL never wrap; mem_addr adds 32-bit, overflow discarded.
REQ-026 DONE: done=1 one cycle, then IDLE; a start sampled in DONE SHALL be ignored.
REQ-027 mem_req SHALL be 0 outside WB/FREQ; mem_ack while mem_req=0 SHALL be ignored.
REQ-028 Minimum per-word latency: 3 cycles write-back (ack in first WB cycle), 2 cycles fill.

Reset
REQ-029 reset_n low at an edge SHALL force IDLE, idx=0, pending fill cleared, all outputs 0, including mid-operation and mid-handshake.
REQ-030 No done pulse SHALL be produced for an operation aborted by reset.

Configuration
REQ-031 Macro DCACHE_FLUSH_FILL_EN defined: fill path (FREQ, FWR, fill_start) present per REQ-015..024.
REQ-032 Macro DCACHE_FLUSH_FILL_EN undefined: fill_start ignored, FREQ/FWR absent, flush_we and flush_in tied 0, mem_we=1 whenever mem_req=1.

Verification
REQ-033 Memblock preset word i=0x1000+i, mem_base=0x2003, flush_start, ack same cycle -> 32 writes addr 0x2000+4i data 0x1000+i, done at cycle 97 after start, busy low with done.
REQ-034 fill_start, memory returns 0xA5A50000+i after 3-cycle ack delay -> flush_we pulses 32 times, memblock word i=0xA5A50000+i, done once.
REQ-035 flush_start and fill_start same cycle -> 32 writes then 32 reads, no IDLE between, single done.
REQ-036 reset_n low in WB at idx=7 with mem_ack low -> next cycle all outputs 0, no done; new flush_start restarts at addr base+0.
REQ-037 flush_start pulses at idx=5 and during DONE, mem_base changed to 0x9000 mid-run -> ignored, addresses stay on original base.
REQ-038 Build without DCACHE_FLUSH_FILL_EN, assert fill_start -> busy stays 0, mem_req stays 0, flush_we stays 0.
